gbuf_arbiter: RTL and testbench
===============================

GBUF_ARBITER -- requirements
Module: gbuf_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, per-bank address width of the global buffer.
REQ-002 SHALL have parameter DATA_BITS, default 8, per-bank data width.
REQ-003 SHALL have ports: clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports per requester N in {0,1}: reqN_valid  input  1  request pending.
REQ-006 SHALL have ports: reqN_wr  input  1  1=write, 0=read.
REQ-007 SHALL have ports: reqN_batch  input  1  1=4-bank wide access, 0=narrow single byte.
REQ-008 SHALL have ports: reqN_index  input  ADDR_BITS+2  buffer index.
REQ-009 SHALL have ports: reqN_wdata  input  4*DATA_BITS  write data; narrow writes use bits [DATA_BITS-1:0].
REQ-010 SHALL have ports: reqN_ready  output  1  request accepted this cycle.
REQ-011 SHALL have ports: reqN_rvalid  output  1  read data valid.
REQ-012 SHALL have ports: reqN_rdata  output  4*DATA_BITS  read data.
REQ-013 SHALL have ports: gb_wr_en, gb_batch_mode  output  1 each; gb_index  output  ADDR_BITS+2; gb_data_in  output  4*DATA_BITS; gb_data_out  input  4*DATA_BITS. All connect to the global buffer.

Function
REQ-014 SHALL accept a request when reqN_valid and reqN_ready are both high in the same cycle (a grant); reqN_ready SHALL be high for at most one N per cycle and MAY depend combinationally on reqN_valid.
REQ-015 SHALL, on a grant, drive gb_wr_en=reqN_wr, gb_batch_mode=reqN_batch, gb_index=reqN_index and gb_data_in=reqN_wdata combinationally in the same cycle.
REQ-016 SHALL, in cycles with no grant, drive gb_wr_en=0 and gb_data_in=0, and hold gb_index and gb_batch_mode at the values registered from the last grant.
REQ-017 SHALL, for a read granted in cycle t, assert reqN_rvalid for exactly cycle t+1 to the granted requester only, with reqN_rdata=gb_data_out; otherwise reqN_rdata=0.
REQ-018 SHALL, after a narrow read (batch=0) grant in cycle t, deassert both readies in cycle t+1 (stall), keeping gb_index and gb_batch_mode stable so that the buffer's index-selected output byte is correct.
REQ-019 SHALL allow back-to-back grants every cycle for writes and batch reads.
REQ-020 SHALL, when only one requester is valid and there is no stall, grant it.
REQ-021 SHALL, when both requesters are valid, resolve contention per REQ-026/REQ-027 and keep the losing request pending; the requester SHALL hold its request stable until granted.
REQ-022 SHALL update the last-grant register (1 bit) on every grant.
REQ-023 SHALL produce no response for writes; write data SHALL be committed at the rising edge ending the grant cycle.

Reset
REQ-024 SHALL, while rst is high, force reqN_ready=0, reqN_rvalid=0, gb_wr_en=0, gb_data_in=0; registered gb_index=0, gb_batch_mode=0, stall=0, last-grant=1 (port 0 wins first contention).
REQ-025 SHALL, on reset asserted mid-operation, drop any pending rvalid or stall; no response SHALL appear after reset release.

Configuration
REQ-026 SHALL, with macro GBUF_ARB_ROUND_ROBIN_EN defined, grant the port not granted last when both are valid (alternating under sustained contention).
REQ-027 SHALL, without GBUF_ARB_ROUND_ROBIN_EN, give port 0 fixed priority over port 1 under contention; the last-grant register MAY be omitted.

Verification
REQ-028 Reset, then req0 batch write index=5 wdata=0x44332211 -> gb_wr_en=1, gb_batch_mode=1, gb_index=5 in the same cycle; req0_ready=1.
REQ-029 req1 batch read index=5 in cycle t -> req1_rvalid=1 and req1_rdata=0x44332211 in t+1; req0_rvalid=0.
REQ-030 req0 narrow read index=0x16 in t, req1 valid in t+1 -> both readies 0 in t+1; gb_index=0x16 held; req0_rdata=0x00000033 in t+1; req1 granted in t+2.
REQ-031 Both requesters hold batch reads for 4 cycles: with round robin -> grants 0,1,0,1; without round robin -> grants 0,0,0,0.
REQ-032 Assert rst in the cycle after a read grant -> no rvalid on either port; after release the first contention is granted to port 0.
REQ-033 Consecutive batch writes on port 1, one per cycle for 8 cycles -> ready=1 each cycle; all 8 words read back correctly.

Source files
------------

// File: rtl/gbuf_arbiter.sv
// Two-port arbiter in front of a 4-bank global buffer; narrow reads stall one cycle for the byte select.
// Optional GBUF_ARB_ROUND_ROBIN_EN: alternate grants under contention instead of fixed port-0 priority.
module gbuf_arbiter #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     req0_valid,
    input  logic                     req0_wr,
    input  logic                     req0_batch,
    input  logic [ADDR_BITS+1:0]     req0_index,
    input  logic [4*DATA_BITS-1:0]   req0_wdata,
    output logic                     req0_ready,
    output logic                     req0_rvalid,
    output logic [4*DATA_BITS-1:0]   req0_rdata,

    input  logic                     req1_valid,
    input  logic                     req1_wr,
    input  logic                     req1_batch,
    input  logic [ADDR_BITS+1:0]     req1_index,
    input  logic [4*DATA_BITS-1:0]   req1_wdata,
    output logic                     req1_ready,
    output logic                     req1_rvalid,
    output logic [4*DATA_BITS-1:0]   req1_rdata,

    output logic                     gb_wr_en,
    output logic                     gb_batch_mode,
    output logic [ADDR_BITS+1:0]     gb_index,
    output logic [4*DATA_BITS-1:0]   gb_data_in,
    input  logic [4*DATA_BITS-1:0]   gb_data_out
);

    // Handshake: a request is taken in the cycle where valid and ready are both high;
    // the requester holds valid and its payload stable until that cycle.

    logic                   stall_q;
    logic                   batch_q;
    logic [ADDR_BITS+1:0]   index_q;
    logic                   rvalid0_q;
    logic                   rvalid1_q;

    logic                   grant0;
    logic                   grant1;
    logic                   grant;
    logic                   sel_wr;
    logic                   sel_batch;
    logic [ADDR_BITS+1:0]   sel_index;
    logic [4*DATA_BITS-1:0] sel_wdata;

`ifdef GBUF_ARB_ROUND_ROBIN_EN
    // last_q = 1 means port 1 was granted last, so port 0 wins the next contention.
    logic last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (grant) begin
            last_q <= grant1;
        end
    end

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && !stall_q) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_q;
                grant1 = !last_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end
`else
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && !stall_q) begin
            grant0 = req0_valid;
            grant1 = req1_valid && !req0_valid;
        end
    end
`endif

    assign grant      = grant0 || grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        sel_wr    = req0_wr;
        sel_batch = req0_batch;
        sel_index = req0_index;
        sel_wdata = req0_wdata;
        if (grant1) begin
            sel_wr    = req1_wr;
            sel_batch = req1_batch;
            sel_index = req1_index;
            sel_wdata = req1_wdata;
        end
    end

    // Between grants the buffer keeps seeing the last index/mode so its byte select stays put.
    assign gb_wr_en      = grant && sel_wr;
    assign gb_batch_mode = grant ? sel_batch : batch_q;
    assign gb_index      = grant ? sel_index : index_q;
    assign gb_data_in    = grant ? sel_wdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q   <= 1'b0;
            batch_q   <= 1'b0;
            index_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            stall_q   <= grant && !sel_wr && !sel_batch;
            rvalid0_q <= grant0 && !req0_wr;
            rvalid1_q <= grant1 && !req1_wr;
            if (grant) begin
                batch_q <= sel_batch;
                index_q <= sel_index;
            end
        end
    end

    assign req0_rvalid = rvalid0_q;
    assign req1_rvalid = rvalid1_q;
    assign req0_rdata  = rvalid0_q ? gb_data_out : '0;
    assign req1_rdata  = rvalid1_q ? gb_data_out : '0;

endmodule

// File: tb/tb_gbuf_arbiter.sv
// Bench for gbuf_arbiter: global-buffer model, byte-level reference model with per-cycle compare, directed vectors.
module tb_gbuf_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_wr, req0_batch;
    logic [9:0]  req0_index;
    logic [31:0] req0_wdata;
    logic        req0_ready, req0_rvalid;
    logic [31:0] req0_rdata;
    logic        req1_valid, req1_wr, req1_batch;
    logic [9:0]  req1_index;
    logic [31:0] req1_wdata;
    logic        req1_ready, req1_rvalid;
    logic [31:0] req1_rdata;
    logic        gb_wr_en, gb_batch_mode;
    logic [9:0]  gb_index;
    logic [31:0] gb_data_in, gb_data_out;

    int checks = 0;
    int errors = 0;

    gbuf_arbiter #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_batch(req0_batch),
        .req0_index(req0_index), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_batch(req1_batch),
        .req1_index(req1_index), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .gb_wr_en(gb_wr_en), .gb_batch_mode(gb_batch_mode), .gb_index(gb_index),
        .gb_data_in(gb_data_in), .gb_data_out(gb_data_out)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Global buffer: registered word read, byte select driven by the current index and mode.
    logic [31:0] buf_mem [0:255];
    logic [31:0] rd_word;

    always @(posedge clk) begin
        if (gb_wr_en) begin
            if (gb_batch_mode) buf_mem[gb_index[7:0]] <= gb_data_in;
            else buf_mem[gb_index[9:2]][gb_index[1:0]*8 +: 8] <= gb_data_in[7:0];
        end
        rd_word <= gb_batch_mode ? buf_mem[gb_index[7:0]] : buf_mem[gb_index[9:2]];
    end

    assign gb_data_out = gb_batch_mode ? rd_word : {24'h0, rd_word[gb_index[1:0]*8 +: 8]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed memory plus the arbitration rules.
    logic [7:0]  ref_mem [0:1023];
    logic        m_stall, m_last, m_batch, m_rv0, m_rv1;
    logic [9:0]  m_idx;
    logic [31:0] m_rd;

    function automatic logic [31:0] ref_read(input logic batch, input logic [9:0] idx);
        logic [31:0] w;
        w = {24'h0, ref_mem[idx]};
        if (batch) w = {ref_mem[{idx[7:0], 2'd3}], ref_mem[{idx[7:0], 2'd2}],
                        ref_mem[{idx[7:0], 2'd1}], ref_mem[{idx[7:0], 2'd0}]};
        return w;
    endfunction

    always @(negedge clk) begin : cmp
        logic g0, g1, e_wr, e_b;
        logic [9:0] e_i;
        logic [31:0] e_d;
        if (rst) begin
            m_stall = 1'b0; m_last = 1'b1; m_batch = 1'b0; m_idx = '0;
            m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd = '0;
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_rvalid0", req0_rvalid, 0);
            chk("rst_rvalid1", req1_rvalid, 0);
            chk("rst_wr_en", gb_wr_en, 0);
            chk("rst_data_in", gb_data_in, 0);
            chk("rst_index", gb_index, 0);
            chk("rst_batch", gb_batch_mode, 0);
        end else begin
            g0 = 1'b0; g1 = 1'b0;
            if (!m_stall) begin
                if (req0_valid && req1_valid) begin
`ifdef GBUF_ARB_ROUND_ROBIN_EN
                    g0 = m_last; g1 = !m_last;
`else
                    g0 = 1'b1;
`endif
                end else begin
                    g0 = req0_valid; g1 = req1_valid;
                end
            end
            e_wr = 1'b0; e_b = m_batch; e_i = m_idx; e_d = '0;
            if (g0) begin e_wr = req0_wr; e_b = req0_batch; e_i = req0_index; e_d = req0_wdata; end
            if (g1) begin e_wr = req1_wr; e_b = req1_batch; e_i = req1_index; e_d = req1_wdata; end
            chk("ready0", req0_ready, g0);
            chk("ready1", req1_ready, g1);
            chk("gb_wr_en", gb_wr_en, e_wr);
            chk("gb_batch_mode", gb_batch_mode, e_b);
            chk("gb_index", gb_index, e_i);
            chk("gb_data_in", gb_data_in, e_d);
            chk("rvalid0", req0_rvalid, m_rv0);
            chk("rvalid1", req1_rvalid, m_rv1);
            chk("rdata0", req0_rdata, m_rv0 ? m_rd : 32'h0);
            chk("rdata1", req1_rdata, m_rv1 ? m_rd : 32'h0);
            // Advance to the state after the coming rising edge.
            m_rv0 = g0 && !e_wr;
            m_rv1 = g1 && !e_wr;
            m_stall = (g0 || g1) && !e_wr && !e_b;
            if (g0 || g1) begin
                m_last = g1; m_idx = e_i; m_batch = e_b;
                if (!e_wr) m_rd = ref_read(e_b, e_i);
                else if (e_b) for (int k = 0; k < 4; k++) ref_mem[{e_i[7:0], 2'(k)}] = e_d[k*8 +: 8];
                else ref_mem[e_i] = e_d[7:0];
            end
        end
    end

    // Driver tasks
    task automatic drive0(input logic v, input logic wr, input logic b, input logic [9:0] i, input logic [31:0] d);
        req0_valid = v; req0_wr = wr; req0_batch = b; req0_index = i; req0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic wr, input logic b, input logic [9:0] i, input logic [31:0] d);
        req1_valid = v; req1_wr = wr; req1_batch = b; req1_index = i; req1_wdata = d;
    endtask

    task automatic mid;
        @(negedge clk); #1;
    endtask

    task automatic next;
        @(posedge clk); #1;
    endtask

    // Hold both pending requests until each is accepted, with a cycle budget.
    task automatic run_pair(input int budget);
        bit d0, d1;
        int n;
        d0 = !req0_valid; d1 = !req1_valid; n = 0;
        while (!(d0 && d1) && n < budget) begin
            mid;
            if (req0_valid && req0_ready) d0 = 1'b1;
            if (req1_valid && req1_ready) d1 = 1'b1;
            next;
            if (d0) req0_valid = 1'b0;
            if (d1) req1_valid = 1'b0;
            n++;
        end
        chk("run_pair_done", {30'h0, d1, d0}, 32'h3);
    endtask

    logic [3:0] gseq;

    initial begin
        for (int i = 0; i < 256; i++) buf_mem[i] = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        rst = 1'b1;
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        repeat (2) next;
        rst = 1'b0;

        // Batch write on port 0
        drive0(1, 1, 1, 10'd5, 32'h44332211);
        mid;
        chk("w5_ready0", req0_ready, 1);
        chk("w5_wr_en", gb_wr_en, 1);
        chk("w5_batch", gb_batch_mode, 1);
        chk("w5_index", gb_index, 5);
        next;
        drive0(0, 0, 0, 0, 0);

        // Batch read on port 1, response one cycle later
        drive1(1, 0, 1, 10'd5, 0);
        mid;
        chk("r5_ready1", req1_ready, 1);
        next;
        drive1(0, 0, 0, 0, 0);
        mid;
        chk("r5_rvalid1", req1_rvalid, 1);
        chk("r5_rdata1", req1_rdata, 32'h44332211);
        chk("r5_rvalid0", req0_rvalid, 0);
        next;

        // Narrow read stalls the following cycle
        drive0(1, 0, 0, 10'h16, 0);
        mid;
        chk("n16_ready0", req0_ready, 1);
        next;
        drive0(0, 0, 0, 0, 0);
        drive1(1, 0, 1, 10'd5, 0);
        mid;
        chk("stall_ready0", req0_ready, 0);
        chk("stall_ready1", req1_ready, 0);
        chk("stall_index", gb_index, 10'h16);
        chk("n16_rvalid0", req0_rvalid, 1);
        chk("n16_rdata0", req0_rdata, 32'h00000033);
        next;
        mid;
        chk("after_stall_ready1", req1_ready, 1);
        next;

        // Sustained contention between two batch reads
        drive0(1, 0, 1, 10'd5, 0);
        drive1(1, 0, 1, 10'd9, 0);
        for (int k = 0; k < 4; k++) begin
            mid;
            gseq[k] = req1_ready;
            chk("cont_one_ready", {31'h0, req0_ready ^ req1_ready}, 1);
            next;
        end
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
`ifdef GBUF_ARB_ROUND_ROBIN_EN
        chk("cont_order", {28'h0, gseq}, 32'ha);
`else
        chk("cont_order", {28'h0, gseq}, 32'h0);
`endif
        next;

        // Reset right after a read grant
        drive0(1, 0, 1, 10'd5, 0);
        next;
        rst = 1'b1;
        drive0(0, 0, 0, 0, 0);
        mid;
        chk("rstmid_rvalid0", req0_rvalid, 0);
        chk("rstmid_rvalid1", req1_rvalid, 0);
        next;
        next;
        rst = 1'b0;
        drive0(1, 0, 1, 10'd5, 0);
        drive1(1, 0, 1, 10'd5, 0);
        mid;
        chk("post_rst_ready0", req0_ready, 1);
        chk("post_rst_ready1", req1_ready, 0);
        next;
        drive0(0, 0, 0, 0, 0);
        run_pair(4);
        next;

        // Eight back-to-back batch writes, then read back
        for (int i = 0; i < 8; i++) begin
            drive1(1, 1, 1, 10'(8 + i), 32'hc0de0000 | 32'(i));
            mid;
            chk("bw_ready1", req1_ready, 1);
            next;
        end
        drive1(0, 0, 0, 0, 0);
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive0(1, 0, 1, 10'(8 + i), 0);
            else drive0(0, 0, 0, 0, 0);
            mid;
            if (i < 8) chk("br_ready0", req0_ready, 1);
            if (i > 0) chk("br_rdata0", req0_rdata, 32'hc0de0000 | 32'(i - 1));
            next;
        end

        // Narrow read and narrow write contending, then read-back
        drive0(1, 0, 0, 10'h17, 0);
        drive1(1, 1, 0, 10'h15, 32'hffffffab);
        run_pair(6);
        next;
        drive0(1, 0, 0, 10'h15, 0);
        next;
        drive0(0, 0, 0, 0, 0);
        mid;
        chk("n15_rdata0", req0_rdata, 32'h000000ab);
        next;
        drive1(1, 0, 1, 10'd5, 0);
        next;
        drive1(0, 0, 0, 0, 0);
        mid;
        chk("w5_merged", req1_rdata, 32'h4433ab11);
        next;
        repeat (3) next;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
